pipe_hazard_unit: RTL
=====================

Name: pipe_hazard_unit

Overview:
- Parametrised pipeline-control block for the 5-stage MIPS CPU.
- Replaces the hazard and stall logic currently in the decoder-side controller.
- Takes decoded register usage from ID and writeback info from EXE/MEM. Produces per-stage enable and flush signals, forwarding selects, and stall/flush performance counters.
- Adds sequential behaviour over the previous generation: a branch-shadow counter, a data-memory wait freeze, and a registered debug single-step.

Parameters:
REG_ADDR_W, 5, register address width
BRANCH_PENALTY, 3, ID squash cycles per accepted branch (legal range 1..7)
CNT_W, 32, width of the saturating performance counters

Ports:
clk  in  1  main clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs_addr  in  REG_ADDR_W  rs address in ID
id_rs_used  in  1  ID reads rs
id_rt_addr  in  REG_ADDR_W  rt address in ID
id_rt_used  in  1  ID reads rt
id_is_branch  in  1  ID instruction is a jump or branch (pc_src != next)
exe_wen  in  1  EXE instruction writes a register
exe_waddr  in  REG_ADDR_W  EXE destination register
exe_is_load  in  1  EXE instruction is a load
mem_wen  in  1  MEM instruction writes a register
mem_waddr  in  REG_ADDR_W  MEM destination register
mem_req  in  1  MEM stage is accessing data memory
mem_ready  in  1  data memory access completes this cycle
debug_en  in  1  debug suspend mode
debug_step  in  1  step request (level; rising edge counts)
if_en, id_en, exe_en, mem_en, wb_en  out  1 each  stage enables
id_flush  out  1  load a bubble into the IF/ID register
exe_flush  out  1  load a bubble into the ID/EXE register
fwd_a_sel  out  2  rs operand source: 00 regfile, 01 EXE result, 10 MEM result
fwd_b_sel  out  2  rt operand source, same encoding
stall_cycles  out  CNT_W  cycles with a data-hazard stall
flush_cycles  out  CNT_W  cycles with id_flush asserted

Behaviour:
- Reset, asynchronous on rst_n low:
  - br_cnt = 0; both counters = 0; step_prev = 1.
  - Outputs while reset is low: all stage enables 1, id_flush = 1, exe_flush = 1, fwd selects 00.
  - A reset mid-branch-shadow or mid-wait discards all pending state.
- Hazard detection:
  - Source hit: a source is used, its address is nonzero, and it equals a stage's waddr with that stage's wen set.
  - raw_stall: any source hits EXE or MEM (this is the no-forwarding rule; see Optional Feature).
- Priority, evaluated each cycle:
  1. Debug hold: debug_en && !step_pulse → all enables 0, no flushes.
     - step_pulse = debug_step && !step_prev; step_prev <= debug_step every cycle.
     - A pulse grants exactly one cycle of normal evaluation.
     - step held high across reset does not produce a pulse.
  2. Memory wait: mem_req && !mem_ready → all enables 0, no flushes, counters frozen.
  3. Data stall: raw_stall && id_valid → if_en = 0, id_en = 0, exe_flush = 1.
     - stall_cycles increments.
     - A branch in ID is not accepted during the stall.
  4. Branch:
     - Accept on id_valid && id_is_branch && br_cnt == 0: id_flush = 1, br_cnt <= BRANCH_PENALTY-1.
     - When br_cnt != 0: id_flush = 1, br_cnt decrements.
     - br_cnt changes only in cycles reaching this level; it holds during levels 1-3.
- flush_cycles increments on every id_flush cycle outside reset.
- Both counters saturate at all-ones and never wrap.
- All decisions are combinational from the current inputs plus registered state; zero-cycle latency to the enables.

Optional Feature:
PIPE_FORWARDING_EN
- Defined:
  - A hit on EXE with exe_is_load stalls; any other hit forwards instead of stalling.
  - Select per operand: EXE (01) takes priority over MEM (10).
  - Register address 0 never forwards.
- Undefined: fwd selects are tied to 00; any EXE/MEM hit stalls.

Decomposition:
- Shared package pipe_ctrl_pkg: FWD_RF / FWD_EXE / FWD_MEM encodings and the sat_inc helper function.
- One natural sub-module, hazard_counter: a saturating counter with enable, instantiated twice.

Test Plan:
1. No-forwarding build: EXE writes $3, ID uses rs=$3 → if_en = id_en = 0, exe_flush = 1. Repeats while $3 sits in MEM, stall_cycles = 2 afterwards.
2. PIPE_FORWARDING_EN build:
   - ALU writes $5 in EXE, ID rt = $5 → fwd_b_sel = 01, no stall.
   - Same case with exe_is_load → one stall cycle, then fwd_b_sel = 10.
3. BRANCH_PENALTY = 3: branch accepted → id_flush high for exactly 3 consecutive cycles, flush_cycles = 3. A second branch in ID during the shadow is ignored.
4. mem_req = 1, mem_ready = 0 for 4 cycles during the branch shadow → enables 0, br_cnt held. The shadow completes after mem_ready rises.
5. debug_en = 1, debug_step held high from reset, then 0→1 → exactly one enabled cycle per rising edge, none at reset release.
6. CNT_W = 4: 20 stall cycles → stall_cycles = 15. rst_n pulsed mid-stall → counters = 0 asynchronously.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/control block.
package pipe_ctrl_pkg;

   localparam int unsigned FWD_W = 2;
   localparam int unsigned SAT_W = 64;

   // Operand source select for the EXE-stage ALU inputs
   typedef enum logic [FWD_W-1:0] {
      FWD_RF  = 2'b00,
      FWD_EXE = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // Per-stage pipeline register enables
   typedef struct packed {
      logic if_en;
      logic id_en;
      logic exe_en;
      logic mem_en;
      logic wb_en;
   } stage_en_t;

   // Increment that sticks at max_value instead of wrapping
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                input logic [SAT_W-1:0] max_value);
      return (value >= max_value) ? value : value + SAT_W'(1);
   endfunction

endpackage

// File: rtl/hazard_counter.sv
// Saturating event counter with increment enable (CNT_W up to 64 bits).
module hazard_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

   // Count enabled events, holding at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc) begin
         count <= CNT_W'(sat_inc(SAT_W'(count), CNT_MAX));
      end
   end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline control for the 5-stage MIPS core: stage enables, flushes,
// forwarding selects, branch shadow, memory-wait freeze, debug single-step
// and saturating stall/flush counters.
// Optional macro PIPE_FORWARDING_EN: enables EXE/MEM operand bypass so only
// load-use hazards stall; when undefined every EXE/MEM hit stalls.
module pipe_hazard_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_W     = 5,
   parameter int unsigned BRANCH_PENALTY = 3,
   parameter int unsigned CNT_W          = 32
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs_addr,
   input  logic                  id_rs_used,
   input  logic [REG_ADDR_W-1:0] id_rt_addr,
   input  logic                  id_rt_used,
   input  logic                  id_is_branch,
   input  logic                  exe_wen,
   input  logic [REG_ADDR_W-1:0] exe_waddr,
   input  logic                  exe_is_load,
   input  logic                  mem_wen,
   input  logic [REG_ADDR_W-1:0] mem_waddr,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   input  logic                  debug_en,
   input  logic                  debug_step,
   output logic                  if_en,
   output logic                  id_en,
   output logic                  exe_en,
   output logic                  mem_en,
   output logic                  wb_en,
   output logic                  id_flush,
   output logic                  exe_flush,
   output logic [FWD_W-1:0]      fwd_a_sel,
   output logic [FWD_W-1:0]      fwd_b_sel,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_cycles
);

   localparam int unsigned   BR_W      = 3;
   localparam logic [BR_W-1:0] BR_RELOAD = BR_W'(BRANCH_PENALTY - 1);

   // A used, nonzero source matching a writing stage's destination
   function automatic logic src_hit(input logic                  used,
                                    input logic [REG_ADDR_W-1:0] addr,
                                    input logic                  wen,
                                    input logic [REG_ADDR_W-1:0] waddr);
      return used && (addr != '0) && wen && (addr == waddr);
   endfunction

   logic            rs_exe_hit, rs_mem_hit, rt_exe_hit, rt_mem_hit;
   logic            raw_stall;
   fwd_sel_e        fwd_a_core, fwd_b_core;
   logic [BR_W-1:0] br_cnt, br_cnt_nxt;
   logic            step_prev;
   logic            step_pulse, debug_hold, mem_wait;
   stage_en_t       en_core;
   logic            id_flush_core, exe_flush_core;
   logic            stall_inc;

   assign rs_exe_hit = src_hit(id_rs_used, id_rs_addr, exe_wen, exe_waddr);
   assign rs_mem_hit = src_hit(id_rs_used, id_rs_addr, mem_wen, mem_waddr);
   assign rt_exe_hit = src_hit(id_rt_used, id_rt_addr, exe_wen, exe_waddr);
   assign rt_mem_hit = src_hit(id_rt_used, id_rt_addr, mem_wen, mem_waddr);

`ifdef PIPE_FORWARDING_EN
   // EXE bypass wins over MEM; a load in EXE has no result to bypass yet
   function automatic fwd_sel_e pick_src(input logic exe_hit, input logic mem_hit);
      if (exe_hit && !exe_is_load) begin
         return FWD_EXE;
      end else if (mem_hit) begin
         return FWD_MEM;
      end
      return FWD_RF;
   endfunction

   assign raw_stall  = exe_is_load & (rs_exe_hit | rt_exe_hit);
   assign fwd_a_core = pick_src(rs_exe_hit, rs_mem_hit);
   assign fwd_b_core = pick_src(rt_exe_hit, rt_mem_hit);
`else
   logic exe_load_hit, exe_alu_hit;

   // Without a bypass path any in-flight producer must drain first
   assign exe_load_hit = exe_is_load  & (rs_exe_hit | rt_exe_hit);
   assign exe_alu_hit  = ~exe_is_load & (rs_exe_hit | rt_exe_hit);
   assign raw_stall    = exe_load_hit | exe_alu_hit | rs_mem_hit | rt_mem_hit;
   assign fwd_a_core   = FWD_RF;
   assign fwd_b_core   = FWD_RF;
`endif

   assign step_pulse = debug_step & ~step_prev;
   assign debug_hold = debug_en & ~step_pulse;
   assign mem_wait   = mem_req & ~mem_ready;

   // Branch-shadow count and step-edge history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt    <= '0;
         step_prev <= 1'b1;
      end else begin
         br_cnt    <= br_cnt_nxt;
         step_prev <= debug_step;
      end
   end

   // Prioritised control decision: debug hold, memory wait, data stall, branch
   always_comb begin
      en_core        = '1;
      id_flush_core  = 1'b0;
      exe_flush_core = 1'b0;
      stall_inc      = 1'b0;
      br_cnt_nxt     = br_cnt;
      if (debug_hold || mem_wait) begin
         en_core = '0;
      end else if (raw_stall && id_valid) begin
         en_core.if_en  = 1'b0;
         en_core.id_en  = 1'b0;
         exe_flush_core = 1'b1;
         stall_inc      = 1'b1;
      end else if (br_cnt != '0) begin
         id_flush_core = 1'b1;
         br_cnt_nxt    = br_cnt - BR_W'(1);
      end else if (id_valid && id_is_branch) begin
         id_flush_core = 1'b1;
         br_cnt_nxt    = BR_RELOAD;
      end
   end

   // Reset forces a fully enabled, fully flushed pipeline with no bypass
   always_comb begin
      if_en     = en_core.if_en;
      id_en     = en_core.id_en;
      exe_en    = en_core.exe_en;
      mem_en    = en_core.mem_en;
      wb_en     = en_core.wb_en;
      id_flush  = id_flush_core;
      exe_flush = exe_flush_core;
      fwd_a_sel = fwd_a_core;
      fwd_b_sel = fwd_b_core;
      if (!rst_n) begin
         if_en     = 1'b1;
         id_en     = 1'b1;
         exe_en    = 1'b1;
         mem_en    = 1'b1;
         wb_en     = 1'b1;
         id_flush  = 1'b1;
         exe_flush = 1'b1;
         fwd_a_sel = FWD_RF;
         fwd_b_sel = FWD_RF;
      end
   end

   hazard_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   hazard_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (id_flush_core),
      .count (flush_cycles)
   );

endmodule
